// File: rtl/cvxif_core_adapter_pkg.sv
// Shared definitions for the core-side CVXIF adapter: opcode and funct3 codes,
// instruction field positions, the adapter state encoding and an encode helper.
package cvxif_core_adapter_pkg;

  localparam logic [6:0] CUSTOM3_OPC = 7'b1111011;

  localparam logic [2:0] FUNCT3_ADD = 3'b000;
  localparam logic [2:0] FUNCT3_SUB = 3'b001;
  localparam logic [2:0] FUNCT3_MUL = 3'b010;
  localparam logic [2:0] FUNCT3_DIV = 3'b011;

  localparam int RD_LSB     = 7;
  localparam int FUNCT3_LSB = 12;
  localparam int RS1_LSB    = 15;
  localparam int RS2_LSB    = 20;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ISSUE     = 3'd1,
    OPERAND   = 3'd2,
    WAIT_RES  = 3'd3,
    WRITEBACK = 3'd4
  } state_t;

  // Builds an R-type custom-3 instruction word.
  function automatic logic [31:0] cvx_encode(input logic [2:0] f3, input logic [4:0] rd,
                                             input logic [4:0] rs1, input logic [4:0] rs2);
    cvx_encode = (32'(rs2) << RS2_LSB) | (32'(rs1) << RS1_LSB) |
                 (32'(f3) << FUNCT3_LSB) | (32'(rd) << RD_LSB) | 32'(CUSTOM3_OPC);
  endfunction

endpackage

// File: rtl/cvxif_core_adapter.sv
// Core-side upstream stage for the posit coprocessor: offers one custom-3
// instruction at a time on the CVXIF issue channel, supplies rs1/rs2 from the
// register file, and writes the returned result back to rd.
module cvxif_core_adapter
  import cvxif_core_adapter_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int RF_AW   = 5,
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                instr_valid,
  output logic                instr_ready,
  input  logic [31:0]         instr,
  output logic                illegal,
  output logic                timeout,
  output logic                busy,
  output logic                x_issue_valid,
  input  logic                x_issue_ready,
  output logic [31:0]         x_issue_instr,
  input  logic                x_issue_accept,
  input  logic                x_issue_wb,
  input  logic [1:0]          x_issue_rread,
  output logic                x_reg_valid,
  output logic [2*XLEN-1:0]   x_reg_rs,
  output logic [1:0]          x_reg_rs_valid,
  input  logic                x_result_valid,
  output logic                x_result_ready,
  input  logic [XLEN-1:0]     x_result_data,
  output logic [RF_AW-1:0]    rf_raddr0,
  output logic [RF_AW-1:0]    rf_raddr1,
  input  logic [XLEN-1:0]     rf_rdata0,
  input  logic [XLEN-1:0]     rf_rdata1,
  output logic                rf_we,
  output logic [RF_AW-1:0]    rf_waddr,
  output logic [XLEN-1:0]     rf_wdata
);

  state_t            state, state_nxt;
  logic [31:0]       instr_q;
  logic              wb_q;
  logic [1:0]        rread_q;
  logic [XLEN-1:0]   rs1_q, rs2_q, res_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              cnt_done;

  assign cnt_done = (cnt_q == CNT_W'(TIMEOUT));

  // Register-file addresses come straight from the latched instruction fields.
  assign rf_raddr0 = instr_q[RS1_LSB +: RF_AW];
  assign rf_raddr1 = instr_q[RS2_LSB +: RF_AW];
  assign rf_waddr  = instr_q[RD_LSB +: RF_AW];
  assign rf_wdata  = res_q;

  // Operands stay frozen for the whole wait so the coprocessor may sample any cycle.
  assign x_reg_rs      = {rs2_q, rs1_q};
  // The coprocessor decodes funct3 at completion, so the word is held until IDLE.
  assign x_issue_instr = (state != IDLE) ? instr_q : 32'd0;
  assign busy          = (state != IDLE);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Transaction context: instruction, issue response, operands, result, wait counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      instr_q <= '0;
      wb_q    <= 1'b0;
      rread_q <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
    end else begin
      case (state)
        IDLE: if (instr_valid) instr_q <= instr;
        ISSUE: if (x_issue_ready && x_issue_accept) begin
          wb_q    <= x_issue_wb;
          rread_q <= x_issue_rread;
        end
        OPERAND: begin
          rs1_q <= rf_rdata0;
          rs2_q <= rf_rdata1;
          cnt_q <= '0;
        end
        WAIT_RES: begin
          cnt_q <= cnt_q + 1'b1;
          if (x_result_valid) res_q <= x_result_data;
        end
        default: ;
      endcase
    end
  end

  // Next-state and handshake outputs; a result arriving on the last wait cycle beats the timeout.
  always_comb begin
    state_nxt      = state;
    instr_ready    = 1'b0;
    x_issue_valid  = 1'b0;
    x_reg_valid    = 1'b0;
    x_reg_rs_valid = 2'b00;
    x_result_ready = 1'b0;
    illegal        = 1'b0;
    timeout        = 1'b0;
    rf_we          = 1'b0;
    case (state)
      IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) state_nxt = ISSUE;
      end
      ISSUE: begin
        x_issue_valid = 1'b1;
        if (x_issue_ready) begin
          if (x_issue_accept) begin
            state_nxt = OPERAND;
          end else begin
            illegal   = 1'b1;
            state_nxt = IDLE;
          end
        end
      end
      OPERAND: state_nxt = WAIT_RES;
      WAIT_RES: begin
        x_reg_valid    = 1'b1;
        x_reg_rs_valid = rread_q;
        x_result_ready = 1'b1;
        if (x_result_valid) begin
          state_nxt = WRITEBACK;
        end else if (cnt_done) begin
          timeout   = 1'b1;
          state_nxt = IDLE;
        end
      end
      WRITEBACK: begin
        rf_we     = wb_q && (rf_waddr != '0);
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_cvxif_core_adapter.sv
// Randomized scoreboard bench for cvxif_core_adapter. The bench plays both the
// core and a coprocessor stub; expected events and operands are queued as each
// transaction is issued and a monitor pops and compares them as the DUT reports.
module tb_cvxif_core_adapter;
  import cvxif_core_adapter_pkg::*;

  localparam int XLEN    = 32;
  localparam int RF_AW   = 5;
  localparam int TIMEOUT = 255;
  localparam int CNT_W   = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              instr_valid, instr_ready;
  logic [31:0]       instr;
  logic              illegal, timeout, busy;
  logic              x_issue_valid, x_issue_ready;
  logic [31:0]       x_issue_instr;
  logic              x_issue_accept, x_issue_wb;
  logic [1:0]        x_issue_rread;
  logic              x_reg_valid;
  logic [2*XLEN-1:0] x_reg_rs;
  logic [1:0]        x_reg_rs_valid;
  logic              x_result_valid, x_result_ready;
  logic [XLEN-1:0]   x_result_data;
  logic [RF_AW-1:0]  rf_raddr0, rf_raddr1, rf_waddr;
  logic [XLEN-1:0]   rf_rdata0, rf_rdata1, rf_wdata;
  logic              rf_we;

  cvxif_core_adapter #(.XLEN(XLEN), .RF_AW(RF_AW), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .illegal(illegal), .timeout(timeout), .busy(busy),
    .x_issue_valid(x_issue_valid), .x_issue_ready(x_issue_ready), .x_issue_instr(x_issue_instr),
    .x_issue_accept(x_issue_accept), .x_issue_wb(x_issue_wb), .x_issue_rread(x_issue_rread),
    .x_reg_valid(x_reg_valid), .x_reg_rs(x_reg_rs), .x_reg_rs_valid(x_reg_rs_valid),
    .x_result_valid(x_result_valid), .x_result_ready(x_result_ready), .x_result_data(x_result_data),
    .rf_raddr0(rf_raddr0), .rf_raddr1(rf_raddr1), .rf_rdata0(rf_rdata0), .rf_rdata1(rf_rdata1),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
  );

  always #5 clk = ~clk;

  // Register file seen by the DUT; loaded with known contents whenever rst is high.
  function automatic logic [31:0] init_val(input int i);
    if (i == 0)               init_val = 32'd0;
    else if (i == 1 || i == 2) init_val = 32'h0000_4000;
    else                       init_val = (32'(i) * 32'h0103_0507) ^ 32'h5a5a_0000;
  endfunction

  logic [31:0] rf [32];
  logic [31:0] model_rf [32];
  assign rf_rdata0 = rf[rf_raddr0];
  assign rf_rdata1 = rf[rf_raddr1];

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) rf[i] <= init_val(i);
    end else if (rf_we && rf_waddr != '0) begin
      rf[rf_waddr] <= rf_wdata;
    end
  end

  // Expected events: kind is one-hot {timeout, illegal, rf_we}.
  typedef struct packed {
    logic [2:0]  kind;
    logic [4:0]  addr;
    logic [31:0] data;
    logic [31:0] ins;
  } ev_t;
  typedef struct packed {
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [1:0]  rv;
  } op_t;

  localparam logic [2:0] K_WRITE = 3'b001;
  localparam logic [2:0] K_ILL   = 3'b010;
  localparam logic [2:0] K_TMO   = 3'b100;

  ev_t ev_q[$];
  op_t op_q[$];

  // 0: no expectation, 1: busy, 2: idle, 3: idle with cleared operand registers.
  int  exp_mode = 0;
  bit  end_req  = 1'b0;
  int  n_checks = 0;
  int  n_err    = 0;

  task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compares DUT reports against the queued expectations away from the active edge.
  logic reg_valid_d = 1'b0;
  bit   end_seen    = 1'b0;
  always @(negedge clk) begin
    ev_t e;
    op_t o;
    if (!rst) begin
      if (illegal || timeout || rf_we) begin
        if (ev_q.size() == 0) begin
          chk(1'b0, "unexpected_event", 64'({timeout, illegal, rf_we}), 64'd0);
        end else begin
          e = ev_q.pop_front();
          chk({timeout, illegal, rf_we} == e.kind, "event_kind", 64'({timeout, illegal, rf_we}), 64'(e.kind));
          chk(x_issue_instr == e.ins, "issue_instr_held", 64'(x_issue_instr), 64'(e.ins));
          if (e.kind == K_WRITE) begin
            chk(rf_waddr == e.addr, "wb_addr", 64'(rf_waddr), 64'(e.addr));
            chk(rf_wdata == e.data, "wb_data", 64'(rf_wdata), 64'(e.data));
          end
        end
      end
      if (x_reg_valid && !reg_valid_d) begin
        if (op_q.size() == 0) begin
          chk(1'b0, "unexpected_operands", x_reg_rs, 64'd0);
        end else begin
          o = op_q.pop_front();
          chk(x_reg_rs == {o.rs2, o.rs1}, "operands", x_reg_rs, {o.rs2, o.rs1});
          chk(x_reg_rs_valid == o.rv, "operand_valid", 64'(x_reg_rs_valid), 64'(o.rv));
        end
      end
      if (exp_mode == 1) begin
        chk({instr_ready, busy} == 2'b01, "busy_state", 64'({instr_ready, busy}), 64'(2'b01));
      end else if (exp_mode >= 2) begin
        chk({instr_ready, busy, x_issue_valid, x_reg_valid, x_result_ready, rf_we, illegal, timeout} == 8'h80,
            "idle_outputs",
            64'({instr_ready, busy, x_issue_valid, x_reg_valid, x_result_ready, rf_we, illegal, timeout}),
            64'(8'h80));
        chk(x_issue_instr == 32'd0, "idle_issue_instr", 64'(x_issue_instr), 64'd0);
      end
      if (exp_mode == 3) begin
        chk(x_reg_rs == 64'd0, "reset_operands", x_reg_rs, 64'd0);
        chk(x_reg_rs_valid == 2'b00, "reset_rs_valid", 64'(x_reg_rs_valid), 64'd0);
      end
      if (end_req && !end_seen) begin
        end_seen <= 1'b1;
        chk(ev_q.size() == 0, "events_drained", 64'(ev_q.size()), 64'd0);
        chk(op_q.size() == 0, "operands_drained", 64'(op_q.size()), 64'd0);
      end
    end
    reg_valid_d <= x_reg_valid;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One complete instruction. rej: stub rejects. tmo: stub never answers.
  // d: wait cycles before the result. The expected outcome is derived from the
  // architectural rules: reject -> illegal, silence -> timeout, else write rd
  // only when wb is set and rd is not x0.
  task automatic do_txn(input logic [2:0] f3, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input bit rej, input bit wb, input logic [1:0] rr,
                        input bit tmo, input int d, input logic [31:0] res);
    logic [31:0] ins;
    ins = cvx_encode(f3, rd, rs1, rs2);
    instr_valid = 1'b1;
    instr       = ins;
    step();
    instr_valid = 1'b0;
    instr       = $urandom;
    exp_mode    = 1;
    repeat ($urandom_range(0, 2)) step();
    x_issue_ready  = 1'b1;
    x_issue_accept = !rej;
    x_issue_wb     = wb;
    x_issue_rread  = rr;
    if (rej) ev_q.push_back('{kind: K_ILL, addr: 5'd0, data: 32'd0, ins: ins});
    step();
    x_issue_ready  = 1'b0;
    x_issue_accept = 1'(($urandom & 1));
    x_issue_wb     = 1'(($urandom & 1));
    x_issue_rread  = 2'($urandom & 3);
    if (rej) begin
      exp_mode = 2;
      return;
    end
    op_q.push_back('{rs1: model_rf[rs1], rs2: model_rf[rs2], rv: rr});
    step();
    if (tmo) begin
      ev_q.push_back('{kind: K_TMO, addr: 5'd0, data: 32'd0, ins: ins});
      repeat (TIMEOUT + 1) step();
      exp_mode = 2;
      return;
    end
    repeat (d) step();
    x_result_valid = 1'b1;
    x_result_data  = res;
    if (wb && rd != 5'd0) begin
      ev_q.push_back('{kind: K_WRITE, addr: rd, data: res, ins: ins});
      model_rf[rd] = res;
    end
    step();
    x_result_valid = 1'b0;
    x_result_data  = $urandom;
    step();
    exp_mode = 2;
  endtask

  initial begin
    rst = 1'b1;
    instr_valid = 1'b0; instr = '0;
    x_issue_ready = 1'b0; x_issue_accept = 1'b0; x_issue_wb = 1'b0; x_issue_rread = 2'b00;
    x_result_valid = 1'b0; x_result_data = '0;
    for (int i = 0; i < 32; i++) model_rf[i] = init_val(i);
    step(); step();
    rst = 1'b0;
    exp_mode = 3;
    step(); step();

    // ADD x3 = x1 + x2 with a 4-cycle result delay.
    do_txn(FUNCT3_ADD, 5'd3, 5'd1, 5'd2, 1'b0, 1'b1, 2'b11, 1'b0, 4, 32'h0000_5000);
    // Rejected instruction.
    do_txn(FUNCT3_SUB, 5'd5, 5'd3, 5'd4, 1'b1, 1'b1, 2'b11, 1'b0, 0, 32'd0);
    step();
    // Result to x0 is consumed and discarded.
    do_txn(FUNCT3_MUL, 5'd0, 5'd1, 5'd3, 1'b0, 1'b1, 2'b01, 1'b0, 2, 32'h0000_1234);
    // wb=0 discards too.
    do_txn(FUNCT3_DIV, 5'd7, 5'd2, 5'd6, 1'b0, 1'b0, 2'b10, 1'b0, 1, 32'hdead_beef);
    // No result ever: timeout at count TIMEOUT.
    do_txn(FUNCT3_MUL, 5'd8, 5'd1, 5'd2, 1'b0, 1'b1, 2'b11, 1'b1, 0, 32'd0);
    // Result on the last permitted cycle beats the timeout.
    do_txn(FUNCT3_ADD, 5'd9, 5'd3, 5'd8, 1'b0, 1'b1, 2'b11, 1'b0, TIMEOUT, 32'h0bad_cafe);
    // Result in the very first wait cycle.
    do_txn(FUNCT3_SUB, 5'd10, 5'd9, 5'd3, 1'b0, 1'b1, 2'b00, 1'b0, 0, 32'h1357_9bdf);

    for (int n = 0; n < 60; n++) begin
      do_txn(3'($urandom_range(0, 3)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
             5'($urandom_range(0, 31)), ($urandom_range(0, 5) == 0), ($urandom_range(0, 4) != 0),
             2'($urandom_range(0, 3)), ($urandom_range(0, 29) == 0),
             ($urandom_range(0, 19) == 0) ? TIMEOUT : int'($urandom_range(0, 6)), $urandom);
      repeat ($urandom_range(0, 2)) step();
    end

    // Reset while waiting for a result: everything is abandoned and a late result ignored.
    instr_valid = 1'b1;
    instr       = cvx_encode(FUNCT3_MUL, 5'd4, 5'd1, 5'd2);
    step();
    instr_valid    = 1'b0;
    exp_mode       = 1;
    x_issue_ready  = 1'b1;
    x_issue_accept = 1'b1;
    x_issue_wb     = 1'b1;
    x_issue_rread  = 2'b11;
    step();
    x_issue_ready = 1'b0;
    op_q.push_back('{rs1: model_rf[1], rs2: model_rf[2], rv: 2'b11});
    step();
    repeat (3) step();
    exp_mode = 0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 32; i++) model_rf[i] = init_val(i);
    exp_mode = 3;
    x_result_valid = 1'b1;
    x_result_data  = 32'h7777_7777;
    step();
    x_result_valid = 1'b0;
    repeat (3) step();

    end_req = 1'b1;
    step(); step();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
